vid_frame_regulator: RTL and testbench

AXI4-Stream video stage directly downstream of video_mux. It enforces the configured frame geometry on the muxed stream so downstream processing always sees well-formed frames:
- every frame starts with TUSER (SOF);
- every line carries exactly cfg_width beats, with TLAST on the last beat;
- every frame carries exactly cfg_height lines.

Short lines are padded, long lines are truncated, and junk between frames is dropped. Error events are reported on status outputs.

---
 rtl/vid_frame_reg_pkg.sv | 19 +
 rtl/vid_axis_out_slice.sv | 46 ++++
 rtl/vid_frame_regulator.sv | 199 +++++++++++++++++++
 tb/tb_vid_frame_regulator.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_frame_reg_pkg.sv
// Shared types and helpers for the video frame regulator: FSM states,
// status counter width and a saturating increment.
package vid_frame_reg_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        WAIT_SOF,
        PASS,
        PAD_LINE,
        DROP_LINE,
        PAD_FRAME
    } reg_state_t;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/vid_axis_out_slice.sv
// Single-entry AXI4-Stream output register. A new beat loads only when the
// slot is empty or the current beat is being taken, so a stalled beat holds.
module vid_axis_out_slice #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_user,
    input  logic                  in_last,
    input  logic                  in_eof,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_user,
    output logic                  m_last,
    output logic                  m_eof,
    input  logic                  m_ready
);

    logic load_ok;
    assign load_ok = !m_valid || m_ready;

    // NOTE: the payload is reset along with valid because the reset value of
    // m_axis_tdata is architecturally visible, not just a don't-care.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_user  <= 1'b0;
            m_last  <= 1'b0;
            m_eof   <= 1'b0;
        end else if (load_ok) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            m_valid <= in_valid;
            if (in_valid) begin
                m_data <= in_data;
                m_user <= in_user;
                m_last <= in_last;
                m_eof  <= in_eof;
            end
        end
    end

endmodule

// File: rtl/vid_frame_regulator.sv
// Forces the incoming video stream into cfg_width x cfg_height frames: pads
// short lines, truncates long lines, drops inter-frame junk and completes
// frames cut short by an early SOF. Define VID_FRAME_REGULATOR_ERR_CNT_EN to
// build the err_short/err_long/err_sof counters; otherwise they read 0.
module vid_frame_regulator
    import vid_frame_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 24,
    parameter int                    CNT_W      = 12,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [CNT_W-1:0]      cfg_width,
    input  logic [CNT_W-1:0]      cfg_height,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  frame_done,
    output logic [ERR_CNT_W-1:0]  err_short,
    output logic [ERR_CNT_W-1:0]  err_long,
    output logic [ERR_CNT_W-1:0]  err_sof
);

    reg_state_t       state, state_nxt;
    logic [CNT_W-1:0] x, y, w_q, h_q;
    logic [CNT_W-1:0] cfg_w_eff, cfg_h_eff, cur_w, cur_h;
    logic             gap_flagged;

    logic load_ok, accepts, sof_hold, s_fire;
    logic take_pixel, emit_pad, push, junk;
    logic col_end, row_end, at_origin;
    logic inc_short, inc_long, inc_sof;
    logic m_eof;

    // A zero geometry would never terminate a line or frame, so it becomes 1.
    assign cfg_w_eff = (cfg_width  == '0) ? CNT_W'(1) : cfg_width;
    assign cfg_h_eff = (cfg_height == '0) ? CNT_W'(1) : cfg_height;
    assign cur_w     = (state == WAIT_SOF) ? cfg_w_eff : w_q;
    assign cur_h     = (state == WAIT_SOF) ? cfg_h_eff : h_q;

    assign col_end   = (x == cur_w - CNT_W'(1));
    assign row_end   = (y == cur_h - CNT_W'(1));
    assign at_origin = (x == '0) && (y == '0);

    assign load_ok = !m_axis_tvalid || m_axis_tready;

    // ---------------- state register ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= WAIT_SOF;
        else        state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_SOF, PASS: begin
                if (sof_hold) begin
                    state_nxt = PAD_FRAME;
                end else if (take_pixel) begin
                    if (col_end)
                        state_nxt = !s_axis_tlast ? DROP_LINE : (row_end ? WAIT_SOF : PASS);
                    else
                        state_nxt = s_axis_tlast ? PAD_LINE : PASS;
                end
            end
            PAD_LINE: begin
                if (emit_pad && col_end) state_nxt = row_end ? WAIT_SOF : PASS;
            end
            // y wraps to 0 when the truncated line was the frame's last one.
            DROP_LINE: begin
                if (sof_hold)
                    state_nxt = (y == '0) ? WAIT_SOF : PAD_FRAME;
                else if (s_fire && s_axis_tlast)
                    state_nxt = (y == '0) ? WAIT_SOF : PASS;
            end
            PAD_FRAME: begin
                if (emit_pad && col_end && row_end) state_nxt = WAIT_SOF;
            end
            default: state_nxt = WAIT_SOF;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        accepts  = 1'b0;
        sof_hold = 1'b0;
        unique case (state)
            WAIT_SOF: accepts = 1'b1;
            PASS: begin
                sof_hold = s_axis_tvalid && s_axis_tuser && !at_origin;
                accepts  = !sof_hold;
            end
            DROP_LINE: begin
                sof_hold = s_axis_tvalid && s_axis_tuser;
                accepts  = !sof_hold;
            end
            default: accepts = 1'b0;
        endcase
    end

    assign s_axis_tready = load_ok && accepts && !ARESET;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign take_pixel    = s_fire && ((state == WAIT_SOF && s_axis_tuser) || state == PASS);
    assign emit_pad      = load_ok && !ARESET && (state == PAD_LINE || state == PAD_FRAME);
    assign push          = take_pixel || emit_pad;
    assign junk          = s_fire && (state == WAIT_SOF) && !s_axis_tuser;

    // Long-line check wins over short-line check on the W-1 beat.
    assign inc_short = take_pixel && !col_end && s_axis_tlast;
    assign inc_long  = take_pixel &&  col_end && !s_axis_tlast;
    // An SOF that ends an overlong final line is a legitimate next frame.
    assign inc_sof   = (junk && !gap_flagged) ||
                       (sof_hold && !(state == DROP_LINE && y == '0));

    // ---------------- position and geometry ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            x           <= '0;
            y           <= '0;
            w_q         <= CNT_W'(1);
            h_q         <= CNT_W'(1);
            gap_flagged <= 1'b0;
        end else begin
            if (take_pixel && state == WAIT_SOF) begin
                w_q <= cfg_w_eff;
                h_q <= cfg_h_eff;
            end
            if (push) begin
                if (col_end) begin
                    x <= '0;
                    y <= row_end ? '0 : y + CNT_W'(1);
                end else begin
                    x <= x + CNT_W'(1);
                end
            end
            if (take_pixel && state == WAIT_SOF) gap_flagged <= 1'b0;
            else if (junk)                       gap_flagged <= 1'b1;
        end
    end

    vid_axis_out_slice #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_slice (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .in_valid (push),
        .in_data  (take_pixel ? s_axis_tdata : PAD_VALUE),
        .in_user  (take_pixel && state == WAIT_SOF),
        .in_last  (col_end),
        .in_eof   (col_end && row_end),
        .m_valid  (m_axis_tvalid),
        .m_data   (m_axis_tdata),
        .m_user   (m_axis_tuser),
        .m_last   (m_axis_tlast),
        .m_eof    (m_eof),
        .m_ready  (m_axis_tready)
    );

    assign frame_done = m_axis_tvalid && m_axis_tready && m_eof && !ARESET;

    // ---------------- status counters ----------------
`ifdef VID_FRAME_REGULATOR_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] cnt_short, cnt_long, cnt_sof;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_short <= '0;
            cnt_long  <= '0;
            cnt_sof   <= '0;
        end else begin
            if (inc_short) cnt_short <= sat_inc(cnt_short);
            if (inc_long)  cnt_long  <= sat_inc(cnt_long);
            if (inc_sof)   cnt_sof   <= sat_inc(cnt_sof);
        end
    end

    assign err_short = cnt_short;
    assign err_long  = cnt_long;
    assign err_sof   = cnt_sof;
`else
    logic unused_err_strobes;
    assign unused_err_strobes = ^{inc_short, inc_long, inc_sof};

    assign err_short = '0;
    assign err_long  = '0;
    assign err_sof   = '0;
`endif

endmodule

// File: tb/tb_vid_frame_regulator.sv
// Directed bench for vid_frame_regulator: 4x3 frames with short, long,
// early-SOF and junk cases, output backpressure and mid-frame reset.
module tb_vid_frame_regulator;

    localparam int             DW  = 24;
    localparam int             CW  = 12;
    localparam logic [DW-1:0]  PAD = 24'hEEEEEE;
`ifdef VID_FRAME_REGULATOR_ERR_CNT_EN
    localparam int             CNT_EN = 1;
`else
    localparam int             CNT_EN = 0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [CW-1:0] cfg_width = 12'd4;
    logic [CW-1:0] cfg_height = 12'd3;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tuser = 1'b0;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tuser;
    logic          m_tlast;
    logic          frame_done;
    logic [15:0]   err_short, err_long, err_sof;

    int    checks = 0;
    int    failures = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    beat_t out_q[$];
    int    fd_count = 0;
    int    stall_viol = 0;
    bit    bp_en = 1'b0;
    logic  ready_level = 1'b1;

    vid_frame_regulator #(
        .DATA_WIDTH (DW),
        .CNT_W      (CW),
        .PAD_VALUE  (PAD)
    ) dut (
        .ACLK          (aclk),
        .ARESET        (areset),
        .cfg_width     (cfg_width),
        .cfg_height    (cfg_height),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .frame_done    (frame_done),
        .err_short     (err_short),
        .err_long      (err_long),
        .err_sof       (err_sof)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        #1;
        m_tready = bp_en ? ($urandom_range(0, 1) == 1) : ready_level;
    end

    // Output monitor: records handshakes and watches stalled beats for changes.
    beat_t held;
    bit    held_v = 1'b0;
    always @(negedge aclk) begin
        beat_t cur;
        cur = {m_tdata, m_tuser, m_tlast};
        if (!areset) begin
            if (m_tvalid && m_tready) out_q.push_back(cur);
            if (frame_done) fd_count++;
            if (held_v && (!m_tvalid || cur != held)) stall_viol++;
            held_v = m_tvalid && !m_tready;
            held   = cur;
        end else begin
            held_v = 1'b0;
        end
    end

    function automatic string fmt(beat_t b);
        return $sformatf("data=%h user=%b last=%b", b.data, b.user, b.last);
    endfunction

    function automatic int first_diff(int base);
        for (int i = 0; i < exp_q.size() && base + i < out_q.size(); i++)
            if (out_q[base + i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic add_line_in(input int n, input int base, input bit sof, input bit last);
        for (int i = 0; i < n; i++)
            in_q.push_back({DW'(base + i), sof && i == 0, last && i == n - 1});
    endtask

    task automatic add_line_exp(input int n, input int base, input bit sof, input bit last);
        for (int i = 0; i < n; i++)
            exp_q.push_back({DW'(base + i), sof && i == 0, last && i == n - 1});
    endtask

    task automatic add_pad_exp(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({PAD, 1'b0, i == n - 1});
    endtask

    task automatic drive_in();
        int t;
        foreach (in_q[i]) begin
            {s_tdata, s_tuser, s_tlast} = in_q[i];
            s_tvalid = 1'b1;
            t = 0;
            @(negedge aclk);
            while (!s_tready && t < 200) begin
                @(negedge aclk);
                t++;
            end
            if (!s_tready) begin
                checks++;
                failures++;
                $display("FAIL drive_timeout: beat %0d tready=%b, required 1 within 200 cycles", i, s_tready);
                break;
            end
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        in_q.delete();
    endtask

    task automatic drain();
        repeat (30) @(posedge aclk);
        #1;
    endtask

    task automatic apply_reset();
        areset   = 1'b1;
        s_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        @(negedge aclk);
        checks++;
        if (s_tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_tready: got %b, expected 0", s_tready);
        end
        @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({m_tvalid, m_tuser, m_tlast, frame_done} !== 4'b0000 || m_tdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid/user/last/done=%b%b%b%b data=%h, expected 0000 000000",
                     m_tvalid, m_tuser, m_tlast, frame_done, m_tdata);
        end
        checks++;
        if ({err_short, err_long, err_sof} !== 48'd0) begin
            failures++;
            $display("FAIL reset_counters: got %0d/%0d/%0d, expected 0/0/0", err_short, err_long, err_sof);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (s_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_tready: got %b, expected 1", s_tready);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_clean();
        int base, fd0, n, d;
        apply_reset();
        base = out_q.size();
        fd0  = fd_count;
        exp_q.delete();
        for (int l = 0; l < 3; l++) begin
            add_line_in(4, 'h100 + 16 * l, l == 0, 1'b1);
            add_line_exp(4, 'h100 + 16 * l, l == 0, 1'b1);
        end
        drive_in();
        drain();
        n = out_q.size() - base;
        checks++;
        if (n !== exp_q.size()) begin
            failures++;
            $display("FAIL clean_count: got %0d beats, expected %0d", n, exp_q.size());
        end
        d = first_diff(base);
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL clean_beat%0d: got %s, expected %s", d, fmt(out_q[base + d]), fmt(exp_q[d]));
        end
        checks++;
        if (fd_count - fd0 !== 1) begin
            failures++;
            $display("FAIL clean_frame_done: got %0d pulses, expected 1", fd_count - fd0);
        end
        checks++;
        if ({err_short, err_long, err_sof} !== 48'd0) begin
            failures++;
            $display("FAIL clean_counters: got %0d/%0d/%0d, expected 0/0/0", err_short, err_long, err_sof);
        end
    endtask

    task automatic test_short_line();
        int base, n, d;
        apply_reset();
        base = out_q.size();
        exp_q.delete();
        add_line_in(4, 'h100, 1'b1, 1'b1);
        add_line_in(2, 'h110, 1'b0, 1'b1);
        add_line_in(4, 'h120, 1'b0, 1'b1);
        add_line_exp(4, 'h100, 1'b1, 1'b1);
        add_line_exp(2, 'h110, 1'b0, 1'b0);
        add_pad_exp(2);
        add_line_exp(4, 'h120, 1'b0, 1'b1);
        drive_in();
        drain();
        n = out_q.size() - base;
        checks++;
        if (n !== exp_q.size()) begin
            failures++;
            $display("FAIL short_count: got %0d beats, expected %0d", n, exp_q.size());
        end
        d = first_diff(base);
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL short_beat%0d: got %s, expected %s", d, fmt(out_q[base + d]), fmt(exp_q[d]));
        end
        checks++;
        if (err_short !== 16'(CNT_EN) || err_long !== 16'd0) begin
            failures++;
            $display("FAIL short_counters: got short=%0d long=%0d, expected short=%0d long=0",
                     err_short, err_long, CNT_EN);
        end
    endtask

    task automatic test_long_line();
        int base, fd0, n, d;
        apply_reset();
        base = out_q.size();
        fd0  = fd_count;
        exp_q.delete();
        add_line_in(6, 'h100, 1'b1, 1'b1);
        add_line_in(4, 'h110, 1'b0, 1'b1);
        add_line_in(4, 'h120, 1'b0, 1'b1);
        add_line_exp(4, 'h100, 1'b1, 1'b1);
        add_line_exp(4, 'h110, 1'b0, 1'b1);
        add_line_exp(4, 'h120, 1'b0, 1'b1);
        drive_in();
        drain();
        n = out_q.size() - base;
        checks++;
        if (n !== exp_q.size()) begin
            failures++;
            $display("FAIL long_count: got %0d beats, expected %0d", n, exp_q.size());
        end
        d = first_diff(base);
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL long_beat%0d: got %s, expected %s", d, fmt(out_q[base + d]), fmt(exp_q[d]));
        end
        checks++;
        if (err_long !== 16'(CNT_EN) || err_short !== 16'd0 || fd_count - fd0 !== 1) begin
            failures++;
            $display("FAIL long_status: got long=%0d short=%0d done=%0d, expected long=%0d short=0 done=1",
                     err_long, err_short, fd_count - fd0, CNT_EN);
        end
    endtask

    task automatic test_sof_mid_frame();
        int base, fd0, n, d;
        apply_reset();
        base = out_q.size();
        fd0  = fd_count;
        exp_q.delete();
        add_line_in(4, 'h100, 1'b1, 1'b1);
        add_line_in(2, 'h110, 1'b0, 1'b0);
        for (int l = 0; l < 3; l++) add_line_in(4, 'h200 + 16 * l, l == 0, 1'b1);
        add_line_exp(4, 'h100, 1'b1, 1'b1);
        add_line_exp(2, 'h110, 1'b0, 1'b0);
        add_pad_exp(2);
        add_pad_exp(4);
        for (int l = 0; l < 3; l++) add_line_exp(4, 'h200 + 16 * l, l == 0, 1'b1);
        drive_in();
        drain();
        n = out_q.size() - base;
        checks++;
        if (n !== exp_q.size()) begin
            failures++;
            $display("FAIL sofmid_count: got %0d beats, expected %0d", n, exp_q.size());
        end
        d = first_diff(base);
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL sofmid_beat%0d: got %s, expected %s", d, fmt(out_q[base + d]), fmt(exp_q[d]));
        end
        checks++;
        if (err_sof !== 16'(CNT_EN) || err_short !== 16'd0 || fd_count - fd0 !== 2) begin
            failures++;
            $display("FAIL sofmid_status: got sof=%0d short=%0d done=%0d, expected sof=%0d short=0 done=2",
                     err_sof, err_short, fd_count - fd0, CNT_EN);
        end
    endtask

    task automatic test_junk_before_sof();
        int base, fd0, n, d;
        apply_reset();
        base = out_q.size();
        fd0  = fd_count;
        exp_q.delete();
        add_line_in(3, 'h0AA, 1'b0, 1'b1);
        for (int l = 0; l < 3; l++) begin
            add_line_in(4, 'h300 + 16 * l, l == 0, 1'b1);
            add_line_exp(4, 'h300 + 16 * l, l == 0, 1'b1);
        end
        drive_in();
        drain();
        n = out_q.size() - base;
        checks++;
        if (n !== exp_q.size()) begin
            failures++;
            $display("FAIL junk_count: got %0d beats, expected %0d", n, exp_q.size());
        end
        d = first_diff(base);
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL junk_beat%0d: got %s, expected %s", d, fmt(out_q[base + d]), fmt(exp_q[d]));
        end
        checks++;
        if (err_sof !== 16'(CNT_EN) || fd_count - fd0 !== 1) begin
            failures++;
            $display("FAIL junk_status: got sof=%0d done=%0d, expected sof=%0d done=1",
                     err_sof, fd_count - fd0, CNT_EN);
        end
    endtask

    task automatic test_one_pixel_lines();
        int base, fd0, n, d;
        cfg_width  = 12'd0;
        cfg_height = 12'd2;
        apply_reset();
        base = out_q.size();
        fd0  = fd_count;
        exp_q.delete();
        add_line_in(1, 'h400, 1'b1, 1'b1);
        add_line_in(1, 'h401, 1'b0, 1'b1);
        add_line_exp(1, 'h400, 1'b1, 1'b1);
        add_line_exp(1, 'h401, 1'b0, 1'b1);
        drive_in();
        drain();
        n = out_q.size() - base;
        checks++;
        if (n !== exp_q.size()) begin
            failures++;
            $display("FAIL onepix_count: got %0d beats, expected %0d", n, exp_q.size());
        end
        d = first_diff(base);
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL onepix_beat%0d: got %s, expected %s", d, fmt(out_q[base + d]), fmt(exp_q[d]));
        end
        checks++;
        if ({err_short, err_long, err_sof} !== 48'd0 || fd_count - fd0 !== 1) begin
            failures++;
            $display("FAIL onepix_status: got %0d/%0d/%0d done=%0d, expected 0/0/0 done=1",
                     err_short, err_long, err_sof, fd_count - fd0);
        end
        cfg_width  = 12'd4;
        cfg_height = 12'd3;
    endtask

    task automatic test_backpressure();
        int base, fd0, sv0, n, d;
        apply_reset();
        base = out_q.size();
        fd0  = fd_count;
        sv0  = stall_viol;
        exp_q.delete();
        for (int l = 0; l < 3; l++) begin
            add_line_in(4, 'h500 + 16 * l, l == 0, 1'b1);
            add_line_exp(4, 'h500 + 16 * l, l == 0, 1'b1);
        end
        bp_en = 1'b1;
        drive_in();
        repeat (20) @(posedge aclk);
        bp_en = 1'b0;
        drain();
        n = out_q.size() - base;
        checks++;
        if (n !== exp_q.size()) begin
            failures++;
            $display("FAIL bp_count: got %0d beats, expected %0d", n, exp_q.size());
        end
        d = first_diff(base);
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL bp_beat%0d: got %s, expected %s", d, fmt(out_q[base + d]), fmt(exp_q[d]));
        end
        checks++;
        if (stall_viol - sv0 !== 0 || fd_count - fd0 !== 1) begin
            failures++;
            $display("FAIL bp_hold: got %0d stall changes done=%0d, expected 0 changes done=1",
                     stall_viol - sv0, fd_count - fd0);
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        ready_level = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        add_line_in(1, 'h600, 1'b1, 1'b0);
        drive_in();
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_pre: got valid=%b tready=%b, expected valid=1 tready=0", m_tvalid, s_tready);
        end
        @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0 || s_tready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear: got valid=%b data=%h tready=%b, expected valid=0 data=000000 tready=0",
                     m_tvalid, m_tdata, s_tready);
        end
        @(posedge aclk);
        #1;
        areset      = 1'b0;
        ready_level = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_short_line();
        test_long_line();
        test_sof_mid_frame();
        test_junk_before_sof();
        test_one_pixel_lines();
        test_backpressure();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
